regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources:
  - Port A: the in-order pipeline writeback, highest priority, no backpressure.
  - Port B: the long-latency unit (MDU), valid/ready, buffered in a small FIFO.
- Keeps a scoreboard of registers with outstanding long-latency results, so issue can stall on RAW/WAW hazards.
- Guarantees B forward progress by requesting a pipeline bubble.
- Sits between the writeback stage and the register file write inputs (we/rd_addr/rd_wdata).

---
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources and the register-file write port.
// Handshake: a B result transfers on a clock edge where b_valid && b_ready; A has no backpressure.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  b_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output b_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline (A) over buffered MDU results (B), plus busy scoreboard.
// Optional macro WB_ARB_PERF_EN adds perf_hold_cycles / perf_bstall_cycles counters.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int REG_DEPTH    = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  input  logic [4:0]           chk_rd,
  output logic                 hazard,
  output logic                 pipe_hold,
  output logic [CNT_W-1:0]     fifo_count
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]          perf_hold_cycles,
  output logic [31:0]          perf_bstall_cycles
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [4:0]           fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [SW-1:0]        starve_cnt, starve_nxt;
  logic [REG_DEPTH-1:0] busy, busy_nxt;
  logic                 rf_we_q, rf_from_b;
  logic [4:0]           rf_waddr_q;
  logic [XLEN-1:0]      rf_wdata_q;
  logic                 sel_a, fifo_ne, b_acc, pop, bypass, push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign wb.b_ready = rst_n && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign wb.rf_we    = rf_we_q;
  assign wb.rf_waddr = rf_waddr_q;
  assign wb.rf_wdata = rf_wdata_q;

  // Register-0 writes never win the port; B ones are swallowed without a FIFO slot.
  always_comb begin
    sel_a   = wb.a_valid && (wb.a_rd != 5'd0);
    fifo_ne = (fifo_count != '0);
    b_acc   = wb.b_valid && wb.b_ready;
    pop     = !sel_a && fifo_ne;
    bypass  = !sel_a && !fifo_ne && b_acc && (wb.b_rd != 5'd0);
    push    = b_acc && (wb.b_rd != 5'd0) && !bypass;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!fifo_ne || pop)
      starve_nxt = '0;
    else if (starve_cnt < SW'(STARVE_LIMIT))
      starve_nxt = starve_cnt + 1'b1;
  end

  // A retiring B write clears its bit; a same-cycle issue to that register re-sets it.
  always_comb begin
    busy_nxt = busy;
    if (rf_we_q && rf_from_b)
      busy_nxt[rf_waddr_q] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0))
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_from_b  <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
      busy       <= '0;
    end else begin
      rf_we_q   <= sel_a || pop || bypass;
      rf_from_b <= !sel_a && (pop || bypass);
      if (sel_a) begin
        rf_waddr_q <= wb.a_rd;
        rf_wdata_q <= wb.a_data;
      end else if (pop) begin
        rf_waddr_q <= fifo_rd[rd_ptr];
        rf_wdata_q <= fifo_data[rd_ptr];
      end else if (bypass) begin
        rf_waddr_q <= wb.b_rd;
        rf_wdata_q <= wb.b_data;
      end else begin
        rf_waddr_q <= '0;
        rf_wdata_q <= '0;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !push)
        fifo_count <= fifo_count - 1'b1;
      starve_cnt <= starve_nxt;
      pipe_hold  <= (starve_nxt >= SW'(STARVE_LIMIT));
      busy       <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= wb.b_rd;
      fifo_data[wr_ptr] <= wb.b_data;
    end
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hold_cycles   <= '0;
      perf_bstall_cycles <= '0;
    end else begin
      if (pipe_hold)                    perf_hold_cycles   <= perf_hold_cycles + 1'b1;
      if (wb.b_valid && !wb.b_ready)    perf_bstall_cycles <= perf_bstall_cycles + 1'b1;
    end
  end
`endif

  // The pipeline owes a bubble in the cycle after it sees pipe_hold.
  hold_honoured: assert property (@(posedge clk) disable iff (!rst_n)
    $past(pipe_hold) |-> !wb.a_valid);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
  logic       clk;
  logic       rst_n;
  logic       iss_valid;
  logic [4:0] iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic       hazard, pipe_hold;
  logic [1:0] fifo_count;
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_hold_cycles, perf_bstall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if #(.XLEN(32)) wb ();

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (wb),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .hazard     (hazard),
    .pipe_hold  (pipe_hold),
    .fifo_count (fifo_count)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_hold_cycles   (perf_hold_cycles),
    .perf_bstall_cycles (perf_bstall_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.a_valid = 1'b0; wb.a_rd = '0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_rd = '0; wb.b_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb.a_valid = v; wb.a_rd = rd; wb.a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb.b_valid = v; wb.b_rd = rd; wb.b_data = d;
  endtask

  task automatic probe(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    chk_rs1 = r1; chk_rs2 = r2; chk_rd = rd;
    #1;
  endtask

  initial begin
    logic any_haz;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_bready", {31'd0, wb.b_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // idle after reset
    check("idle_we",    {31'd0, wb.rf_we}, 32'd0);
    check("idle_waddr", {27'd0, wb.rf_waddr}, 32'd0);
    check("idle_wdata", wb.rf_wdata, 32'd0);
    check("idle_count", {30'd0, fifo_count}, 32'd0);
    check("idle_hold",  {31'd0, pipe_hold}, 32'd0);
    check("idle_bready", {31'd0, wb.b_ready}, 32'd1);
    any_haz = 1'b0;
    for (int i = 0; i < 32; i++) begin
      probe(5'(i), 5'(i), 5'(i));
      any_haz = any_haz | hazard;
    end
    check("idle_hazard", {31'd0, any_haz}, 32'd0);
    probe(0, 0, 0);

    // A write and A write to x0
    drive_a(1, 5, 32'hDEADBEEF);
    step();
    drive_a(0, 0, 0);
    check("a_we",    {31'd0, wb.rf_we}, 32'd1);
    check("a_waddr", {27'd0, wb.rf_waddr}, 32'd5);
    check("a_wdata", wb.rf_wdata, 32'hDEADBEEF);
    drive_a(1, 0, 32'h1111);
    step();
    drive_a(0, 0, 0);
    check("a_x0_we", {31'd0, wb.rf_we}, 32'd0);

    // scoreboard set via issue, hazard on each checked field
    iss_valid = 1'b1; iss_rd = 7;
    step();
    iss_valid = 1'b0;
    probe(7, 0, 0);
    check("haz_rs1", {31'd0, hazard}, 32'd1);
    probe(0, 7, 0);
    check("haz_rs2", {31'd0, hazard}, 32'd1);
    probe(0, 0, 7);
    check("haz_rd", {31'd0, hazard}, 32'd1);
    probe(8, 6, 0);
    check("haz_other", {31'd0, hazard}, 32'd0);

    // B bypass retires rd 7
    probe(7, 0, 0);
    drive_b(1, 7, 32'h12);
    #1;
    check("byp_bready", {31'd0, wb.b_ready}, 32'd1);
    step();
    drive_b(0, 0, 0);
    check("byp_we",    {31'd0, wb.rf_we}, 32'd1);
    check("byp_waddr", {27'd0, wb.rf_waddr}, 32'd7);
    check("byp_wdata", wb.rf_wdata, 32'h12);
    check("byp_count", {30'd0, fifo_count}, 32'd0);
    check("byp_haz_during", {31'd0, hazard}, 32'd1);
    step();
    check("byp_haz_after", {31'd0, hazard}, 32'd0);
    check("byp_we_done", {31'd0, wb.rf_we}, 32'd0);

    // B to x0 is accepted and dropped
    drive_b(1, 0, 32'h55);
    #1;
    check("bx0_bready", {31'd0, wb.b_ready}, 32'd1);
    step();
    drive_b(0, 0, 0);
    check("bx0_we",    {31'd0, wb.rf_we}, 32'd0);
    check("bx0_count", {30'd0, fifo_count}, 32'd0);

    // starvation: A busy every cycle, B queues rd 3 then rd 4
    drive_a(1, 10, 32'hA0);
    drive_b(1, 3, 32'h33);
    step();
    check("st_a_waddr", {27'd0, wb.rf_waddr}, 32'd10);
    check("st_count1",  {30'd0, fifo_count}, 32'd1);
    drive_b(1, 4, 32'h44);
    step();
    drive_b(0, 0, 0);
    check("st_count2",  {30'd0, fifo_count}, 32'd2);
    check("st_full_bready", {31'd0, wb.b_ready}, 32'd0);
    step();
    step();
    check("st_hold_early", {31'd0, pipe_hold}, 32'd0);
    step();
    check("st_hold", {31'd0, pipe_hold}, 32'd1);
    drive_a(0, 0, 0);
    step();
    check("st_pop1_we",    {31'd0, wb.rf_we}, 32'd1);
    check("st_pop1_waddr", {27'd0, wb.rf_waddr}, 32'd3);
    check("st_pop1_wdata", wb.rf_wdata, 32'h33);
    check("st_hold_clear", {31'd0, pipe_hold}, 32'd0);
    check("st_count_pop1", {30'd0, fifo_count}, 32'd1);
    step();
    check("st_pop2_waddr", {27'd0, wb.rf_waddr}, 32'd4);
    check("st_pop2_wdata", wb.rf_wdata, 32'h44);
    check("st_count_pop2", {30'd0, fifo_count}, 32'd0);
    step();
    check("st_drained_we", {31'd0, wb.rf_we}, 32'd0);

    // same-cycle set and clear of rd 9: set wins
    iss_valid = 1'b1; iss_rd = 9;
    step();
    iss_valid = 1'b0;
    drive_b(1, 9, 32'h99);
    step();
    drive_b(0, 0, 0);
    check("sc_we", {31'd0, wb.rf_we}, 32'd1);
    iss_valid = 1'b1; iss_rd = 9;
    step();
    iss_valid = 1'b0;
    probe(9, 0, 0);
    check("sc_busy_kept", {31'd0, hazard}, 32'd1);
    step();
    check("sc_busy_still", {31'd0, hazard}, 32'd1);
    drive_b(1, 9, 32'h9A);
    step();
    drive_b(0, 0, 0);
    step();
    check("sc_busy_cleared", {31'd0, hazard}, 32'd0);

    // reset with two FIFO entries and busy bits set
    probe(0, 0, 0);
    drive_a(1, 12, 32'hC0);
    drive_b(1, 3, 32'h3);
    iss_valid = 1'b1; iss_rd = 11;
    step();
    drive_b(1, 4, 32'h4);
    iss_rd = 13;
    step();
    drive_b(0, 0, 0);
    iss_valid = 1'b0;
    check("mr_count_pre", {30'd0, fifo_count}, 32'd2);
    probe(11, 13, 0);
    check("mr_haz_pre", {31'd0, hazard}, 32'd1);
    drive_a(0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("mr_bready_low", {31'd0, wb.b_ready}, 32'd0);
    check("mr_count_rst", {30'd0, fifo_count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_count", {30'd0, fifo_count}, 32'd0);
    check("mr_we",    {31'd0, wb.rf_we}, 32'd0);
    check("mr_haz",   {31'd0, hazard}, 32'd0);
    check("mr_bready", {31'd0, wb.b_ready}, 32'd1);
    step();
    check("mr_we_late", {31'd0, wb.rf_we}, 32'd0);
    check("mr_hold", {31'd0, pipe_hold}, 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
